// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and helpers for the memory responder
//
// Purpose: per-channel FSM state and op encodings, latency counter width and
// the saturating counter helper used by the top level.
// Ports: none (package).

package mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RECOVER} ch_state_t;
  typedef enum logic {OP_READ, OP_WRITE} ch_op_t;

  // Latency counter width; LATENCY must stay within 1..15.
  localparam int CNT_BITS = 4;

  // 16-bit counter add that sticks at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [7:0] inc);
    logic [16:0] sum;
    sum = {1'b0, base} + {9'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - multi-channel valid/ready memory bus
//
// Purpose: bundles the per-channel read and write handshakes between the
// memory controllers (master) and the memory responder (slave).
// Signals (all per channel, packed [NUM_CHANNELS-1:0]):
//   mem_read_valid / mem_read_address          master -> slave
//   mem_read_ready / mem_read_data             slave  -> master
//   mem_write_valid / mem_write_address / data master -> slave
//   mem_write_ready                            slave  -> master

interface mem_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/mem_responder_channel.sv
// rtl/mem_responder_channel.sv - one request channel: FSM, latency counter, latched request
//
// Purpose: accepts one read or write at a time, waits LATENCY cycles and then
// strobes commit_rd_o/commit_wr_o for exactly the edge that enters RESPOND.
// The top level performs the array access on that strobe.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   read_valid_i, read_address_i     read request from the bus
//   write_valid_i, write_address_i,
//   write_data_i                     write request from the bus
//   read_ready_o, write_ready_o      registered one-cycle response pulses
//   commit_rd_o, commit_wr_o         array access strobes for the current edge
//   commit_addr_o, commit_data_o     address/data that go with the strobes

module mem_responder_channel
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid_i,
  input  logic [ADDR_BITS-1:0] read_address_i,
  input  logic                 write_valid_i,
  input  logic [ADDR_BITS-1:0] write_address_i,
  input  logic [DATA_BITS-1:0] write_data_i,
  output logic                 read_ready_o,
  output logic                 write_ready_o,
  output logic                 commit_rd_o,
  output logic                 commit_wr_o,
  output logic [ADDR_BITS-1:0] commit_addr_o,
  output logic [DATA_BITS-1:0] commit_data_o
);

  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

  ch_state_t            state_q;
  ch_op_t               op_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] data_q;
  logic [CNT_BITS-1:0]  cnt_q;
  logic                 rd_ready_q;
  logic                 wr_ready_q;

  logic accept_rd;
  logic accept_wr;
  logic op_valid;
  logic fire_idle;
  logic fire_busy;

  always_comb begin
    // Read has priority; a simultaneous write stays pending on the bus.
    accept_rd = (state_q == IDLE) && read_valid_i;
    accept_wr = (state_q == IDLE) && !read_valid_i && write_valid_i && (WRITE_ENABLE != 0);
    op_valid  = (op_q == OP_READ) ? read_valid_i : write_valid_i;
    // LATENCY=1 goes straight from IDLE to RESPOND on the accepting edge.
    fire_idle = (accept_rd || accept_wr) && (CNT_INIT == '0);
    // cnt_q==1 here means the decrement reaches 0 on this edge.
    fire_busy = (state_q == BUSY) && op_valid && (cnt_q <= CNT_BITS'(1));
    // Reset suppresses commits so an in-flight op never lands.
    commit_rd_o = !reset && ((fire_idle && accept_rd) || (fire_busy && (op_q == OP_READ)));
    commit_wr_o = !reset && ((fire_idle && accept_wr) || (fire_busy && (op_q == OP_WRITE)));
    // In IDLE the request has not been latched yet, so use the bus directly.
    if (state_q == IDLE) begin
      commit_addr_o = accept_rd ? read_address_i : write_address_i;
      commit_data_o = write_data_i;
    end else begin
      commit_addr_o = addr_q;
      commit_data_o = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      rd_ready_q <= commit_rd_o;
      wr_ready_q <= commit_wr_o;
      case (state_q)
        IDLE: begin
          if (accept_rd || accept_wr) begin
            op_q    <= accept_rd ? OP_READ : OP_WRITE;
            addr_q  <= commit_addr_o;
            data_q  <= write_data_i;
            cnt_q   <= CNT_INIT;
            state_q <= (CNT_INIT == '0) ? RESPOND : BUSY;
          end
        end
        BUSY: begin
          if (!op_valid) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q <= CNT_BITS'(1)) begin
              state_q <= RESPOND;
            end
          end
        end
        RESPOND: state_q <= RECOVER;
        // Wait for the requester to release valid so a held request is not answered twice.
        RECOVER: begin
          if (!op_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_ready_o  = rd_ready_q;
  assign write_ready_o = wr_ready_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - multi-channel fixed-latency memory responder
//
// Purpose: answers program/data memory reads and writes from a local
// 2**ADDR_BITS-word array; a host load port preloads the array.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   mem (mem_responder_if.slave)       per-channel read/write handshakes
//   load_valid, load_address,
//   load_data                          host preload port (beats all channels)
//   reads_served, writes_served        saturating completion counters

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       mem,
  input  logic                 load_valid,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  output logic [15:0]          reads_served,
  output logic [15:0]          writes_served
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Storage is deliberately not reset: preloaded images survive reset.
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [NUM_CHANNELS-1:0]                commit_rd;
  logic [NUM_CHANNELS-1:0]                commit_wr;
  logic [NUM_CHANNELS-1:0]                rd_ready;
  logic [NUM_CHANNELS-1:0]                wr_ready;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] commit_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] commit_data;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q;
  logic [15:0]                            reads_q;
  logic [15:0]                            writes_q;
  logic [7:0]                             rd_cnt;
  logic [7:0]                             wr_cnt;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    mem_responder_channel #(
      .ADDR_BITS   (ADDR_BITS),
      .DATA_BITS   (DATA_BITS),
      .LATENCY     (LATENCY),
      .WRITE_ENABLE(WRITE_ENABLE)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .read_valid_i   (mem.mem_read_valid[g]),
      .read_address_i (mem.mem_read_address[g]),
      .write_valid_i  (mem.mem_write_valid[g]),
      .write_address_i(mem.mem_write_address[g]),
      .write_data_i   (mem.mem_write_data[g]),
      .read_ready_o   (rd_ready[g]),
      .write_ready_o  (wr_ready[g]),
      .commit_rd_o    (commit_rd[g]),
      .commit_wr_o    (commit_wr[g]),
      .commit_addr_o  (commit_addr[g]),
      .commit_data_o  (commit_data[g])
    );
  end

  // Later assignments win: ascending channel order gives the highest index
  // priority, and the load port is applied last so it beats every channel.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (commit_wr[c]) begin
        mem_q[commit_addr[c]] <= commit_data[c];
      end
    end
    if (load_valid) begin
      mem_q[load_address] <= load_data;
    end
  end

  // Reads sample the array before this edge's writes land, so a same-edge
  // read/write hazard returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (commit_rd[c]) begin
          read_data_q[c] <= mem_q[commit_addr[c]];
        end
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    wr_cnt = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rd_cnt = rd_cnt + {7'b0, commit_rd[c]};
      wr_cnt = wr_cnt + {7'b0, commit_wr[c]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else begin
      reads_q  <= sat_add16(reads_q, rd_cnt);
      writes_q <= sat_add16(writes_q, wr_cnt);
    end
  end

  assign mem.mem_read_ready  = rd_ready;
  assign mem.mem_write_ready = (WRITE_ENABLE != 0) ? wr_ready : '0;
  assign mem.mem_read_data   = read_data_q;
  assign reads_served        = reads_q;
  assign writes_served       = writes_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder

module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8),  .NUM_CHANNELS(4)) bus_a ();
  mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8),  .NUM_CHANNELS(4)) bus_b ();
  mem_responder_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4)) bus_c ();

  logic        la_v, lb_v, lc_v;
  logic [7:0]  la_a, la_d, lb_a, lb_d, lc_a;
  logic [15:0] lc_d;
  logic [15:0] ra, wa, rb, wb, rc, wc;

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .mem(bus_a), .load_valid(la_v), .load_address(la_a),
    .load_data(la_d), .reads_served(ra), .writes_served(wa));

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(4), .WRITE_ENABLE(1)) u_dut_b (
    .clk(clk), .reset(reset), .mem(bus_b), .load_valid(lb_v), .load_address(lb_a),
    .load_data(lb_d), .reads_served(rb), .writes_served(wb));

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4), .LATENCY(1), .WRITE_ENABLE(0)) u_dut_c (
    .clk(clk), .reset(reset), .mem(bus_c), .load_valid(lc_v), .load_address(lc_a),
    .load_data(lc_d), .reads_served(rc), .writes_served(wc));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load(input logic [7:0] addr, input logic [7:0] data);
    la_v = 1'b1; la_a = addr; la_d = data;
    tick();
    la_v = 1'b0;
  endtask

  // Single request on DUT A with a bounded wait for the response.
  task automatic a_op(input int ch, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp, input string tag);
    bit seen;
    seen = 1'b0;
    if (wr) begin
      bus_a.mem_write_valid[ch] = 1'b1; bus_a.mem_write_address[ch] = addr; bus_a.mem_write_data[ch] = wdata;
    end else begin
      bus_a.mem_read_valid[ch] = 1'b1; bus_a.mem_read_address[ch] = addr;
    end
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      seen = wr ? bus_a.mem_write_ready[ch] : bus_a.mem_read_ready[ch];
    end
    check({tag, "_ready"}, seen, 1);
    if (!wr && seen) check({tag, "_data"}, bus_a.mem_read_data[ch], exp);
    bus_a.mem_read_valid[ch] = 1'b0; bus_a.mem_write_valid[ch] = 1'b0;
    tick(); tick();
  endtask

  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, a ^ 8'h5A};
  endfunction

  int unsigned req[4], rsp[4], gap[4];
  int unsigned total, bad_data, bad_ready, wr_seen;
  logic [7:0]  c_addr[4];

  // Controller-style handshake on DUT C: hold valid until ready, release for
  // two edges so the channel leaves RECOVER, then issue the next address.
  task automatic c_service(input bit allow_new);
    tick();
    if (bus_c.mem_write_ready != '0) wr_seen++;
    for (int ch = 0; ch < 4; ch++) begin
      if (bus_c.mem_read_ready[ch]) begin
        if (!bus_c.mem_read_valid[ch]) bad_ready++;
        if (bus_c.mem_read_data[ch] != pat(c_addr[ch])) bad_data++;
        rsp[ch]++; total++;
        bus_c.mem_read_valid[ch] = 1'b0;
        gap[ch] = 2;
      end else if (!bus_c.mem_read_valid[ch] && allow_new) begin
        gap[ch]--;
        if (gap[ch] == 0) begin
          c_addr[ch] = c_addr[ch] + 8'(ch + 1);
          bus_c.mem_read_address[ch] = c_addr[ch];
          bus_c.mem_read_valid[ch] = 1'b1;
          req[ch]++;
        end
      end
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    la_v = 1'b0; la_a = '0; la_d = '0;
    lb_v = 1'b0; lb_a = '0; lb_d = '0;
    lc_v = 1'b0; lc_a = '0; lc_d = '0;
    bus_a.mem_read_valid = '0; bus_a.mem_read_address = '0;
    bus_a.mem_write_valid = '0; bus_a.mem_write_address = '0; bus_a.mem_write_data = '0;
    bus_b.mem_read_valid = '0; bus_b.mem_read_address = '0;
    bus_b.mem_write_valid = '0; bus_b.mem_write_address = '0; bus_b.mem_write_data = '0;
    bus_c.mem_read_valid = '0; bus_c.mem_read_address = '0;
    bus_c.mem_write_valid = '0; bus_c.mem_write_address = '0; bus_c.mem_write_data = '0;
    tick(); tick();
    check("rst_a_rready", bus_a.mem_read_ready, 0);
    check("rst_a_wready", bus_a.mem_write_ready, 0);
    check("rst_a_rdata", bus_a.mem_read_data, 0);
    check("rst_a_counts", {ra, wa}, 0);
    check("rst_c_rdata", bus_c.mem_read_data, 0);
    reset = 1'b0;
    tick();

    // 1: preload then read, exact latency and no re-answer while held
    a_load(8'h10, 8'hAB);
    bus_a.mem_read_valid[0] = 1'b1; bus_a.mem_read_address[0] = 8'h10;
    tick(); check("t1_early", bus_a.mem_read_ready[0], 0);
    tick(); check("t1_ready", bus_a.mem_read_ready[0], 1);
    check("t1_data", bus_a.mem_read_data[0], 8'hAB);
    check("t1_reads", ra, 1);
    tick(); check("t1_held1", bus_a.mem_read_ready[0], 0);
    tick(); check("t1_held2", bus_a.mem_read_ready[0], 0);
    check("t1_data_hold", bus_a.mem_read_data[0], 8'hAB);
    bus_a.mem_read_valid[0] = 1'b0;
    tick(); tick();

    // 2: write on ch1, read back on ch2
    a_op(1, 1'b1, 8'h20, 8'h5A, 8'h00, "t2_wr");
    a_op(2, 1'b0, 8'h20, 8'h00, 8'h5A, "t2_rd");
    check("t2_counts", {ra, wa}, {16'd2, 16'd1});

    // 3: same-address write collision, then with the load port on the commit edge
    bus_a.mem_write_valid = 4'b1001;
    bus_a.mem_write_address[0] = 8'h30; bus_a.mem_write_data[0] = 8'h11;
    bus_a.mem_write_address[3] = 8'h30; bus_a.mem_write_data[3] = 8'h33;
    tick(); tick();
    check("t3_wready", bus_a.mem_write_ready, 4'b1001);
    bus_a.mem_write_valid = '0;
    tick(); tick();
    a_op(0, 1'b0, 8'h30, 8'h00, 8'h33, "t3_hi_wins");
    bus_a.mem_write_valid = 4'b1001;
    tick();
    la_v = 1'b1; la_a = 8'h30; la_d = 8'h77;
    tick();
    la_v = 1'b0;
    check("t3_wready_ld", bus_a.mem_write_ready, 4'b1001);
    bus_a.mem_write_valid = '0;
    tick(); tick();
    a_op(0, 1'b0, 8'h30, 8'h00, 8'h77, "t3_load_wins");
    check("t3_counts", {ra, wa}, {16'd4, 16'd5});

    // 4: read/write hazard on the same edge returns the old value
    a_load(8'h40, 8'h01);
    bus_a.mem_read_valid[1] = 1'b1; bus_a.mem_read_address[1] = 8'h40;
    bus_a.mem_write_valid[2] = 1'b1; bus_a.mem_write_address[2] = 8'h40; bus_a.mem_write_data[2] = 8'h02;
    tick(); tick();
    check("t4_rready", bus_a.mem_read_ready, 4'b0010);
    check("t4_wready", bus_a.mem_write_ready, 4'b0100);
    check("t4_old", bus_a.mem_read_data[1], 8'h01);
    bus_a.mem_read_valid = '0; bus_a.mem_write_valid = '0;
    tick(); tick();
    a_op(0, 1'b0, 8'h40, 8'h00, 8'h02, "t4_new");

    // 4b: read and write on one channel: read first, write after RECOVER
    bus_a.mem_read_valid[3] = 1'b1; bus_a.mem_read_address[3] = 8'h10;
    bus_a.mem_write_valid[3] = 1'b1; bus_a.mem_write_address[3] = 8'h50; bus_a.mem_write_data[3] = 8'h99;
    tick(); tick();
    check("t4b_rd_first", {bus_a.mem_read_ready, bus_a.mem_write_ready}, 8'b1000_0000);
    check("t4b_rdata", bus_a.mem_read_data[3], 8'hAB);
    bus_a.mem_read_valid[3] = 1'b0;
    tick(); tick(); tick(); tick();
    check("t4b_wr_later", bus_a.mem_write_ready, 4'b1000);
    bus_a.mem_write_valid[3] = 1'b0;
    tick(); tick();
    a_op(0, 1'b0, 8'h50, 8'h00, 8'h99, "t4b_readback");
    check("t4_counts", {ra, wa}, {16'd8, 16'd7});

    // 5: LATENCY=4, abort in BUSY, then reset on the would-be commit edge
    lb_v = 1'b1; lb_a = 8'h60; lb_d = 8'hC3;
    tick();
    lb_v = 1'b0;
    bus_b.mem_write_valid[0] = 1'b1; bus_b.mem_write_address[0] = 8'h60; bus_b.mem_write_data[0] = 8'h3C;
    tick(); tick();
    bus_b.mem_write_valid[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | (|bus_b.mem_write_ready);
    end
    check("t5_abort_noready", seen, 0);
    check("t5_abort_wcnt", wb, 0);
    bus_b.mem_read_valid[0] = 1'b1; bus_b.mem_read_address[0] = 8'h60;
    tick(); tick(); tick();
    check("t5_lat_early", bus_b.mem_read_ready[0], 0);
    tick();
    check("t5_lat_ready", bus_b.mem_read_ready[0], 1);
    check("t5_unchanged", bus_b.mem_read_data[0], 8'hC3);
    check("t5_rcnt", rb, 1);
    bus_b.mem_read_valid[0] = 1'b0;
    tick(); tick();
    bus_b.mem_write_valid[1] = 1'b1; bus_b.mem_write_address[1] = 8'h60; bus_b.mem_write_data[1] = 8'h3C;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    bus_b.mem_write_valid[1] = 1'b0;
    tick();
    reset = 1'b0;
    check("t5_rst_counts", {rb, wb}, 0);
    check("t5_rst_ready", {bus_b.mem_read_ready, bus_b.mem_write_ready}, 0);
    bus_b.mem_read_valid[1] = 1'b1; bus_b.mem_read_address[1] = 8'h60;
    tick(); tick(); tick(); tick();
    check("t5_post_ready", bus_b.mem_read_ready[1], 1);
    check("t5_post_data", bus_b.mem_read_data[1], 8'hC3);
    check("t5_post_counts", {rb, wb}, {16'd1, 16'd0});
    bus_b.mem_read_valid[1] = 1'b0;
    tick(); tick();

    // 6: read-only 16-bit responder, 4 channels streaming past counter saturation
    for (int a = 0; a < 256; a++) begin
      lc_v = 1'b1; lc_a = 8'(a); lc_d = pat(8'(a));
      tick();
    end
    lc_v = 1'b0;
    total = 0; bad_data = 0; bad_ready = 0; wr_seen = 0;
    for (int ch = 0; ch < 4; ch++) begin
      c_addr[ch] = 8'(ch * 37);
      req[ch] = 1; rsp[ch] = 0; gap[ch] = 0;
      bus_c.mem_read_address[ch] = c_addr[ch];
      bus_c.mem_write_address[ch] = c_addr[ch];
      bus_c.mem_write_data[ch] = 16'hDEAD;
    end
    bus_c.mem_read_valid = 4'b1111;
    bus_c.mem_write_valid = 4'b1111;
    for (int cyc = 0; cyc < 60000 && total < 65540; cyc++) begin
      c_service(1'b1);
      if (cyc == 999) check("t6_mid_count", rc, total);
    end
    bus_c.mem_write_valid = '0;
    for (int i = 0; i < 8; i++) c_service(1'b0);
    for (int ch = 0; ch < 4; ch++) check($sformatf("t6_one_per_req_ch%0d", ch), rsp[ch], req[ch]);
    check("t6_enough", total >= 65536, 1);
    check("t6_bad_data", bad_data, 0);
    check("t6_spurious_ready", bad_ready, 0);
    check("t6_no_wready", wr_seen, 0);
    check("t6_rsat", rc, 16'hFFFF);
    check("t6_wcnt", wc, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
